// File: rtl/vector_add_sequencer.sv
// Vector adder that streams VLEN single-precision element pairs through one shared
// combinational float adder, one element per clock, and holds the sum until it is consumed.

module FloatingAddition (
  input  logic [31:0] a_i,
  input  logic [31:0] b_i,
  output logic [31:0] sum_o
);
  logic        a_nan_s, b_nan_s, a_inf_s, b_inf_s;
  logic        a_ge_s, big_sign_s, small_sign_s;
  logic [31:0] big_s, small_s;
  logic [7:0]  big_exp_s, small_exp_s, diff_s;
  logic [23:0] big_man_s, small_man_s;
  logic [26:0] small_ext_s, aligned_s, norm_s;
  logic [27:0] sum_s;
  logic [4:0]  lz_s, shift_s;
  logic [9:0]  exp_s, shift_lim_s;
  logic        round_up_s;
  logic [24:0] man_r_s;

  // IEEE-754 add, round-to-nearest-even, subnormals handled via an effective exponent of 1
  always_comb begin
    a_nan_s      = (a_i[30:23] == 8'hFF) && (a_i[22:0] != 23'd0);
    b_nan_s      = (b_i[30:23] == 8'hFF) && (b_i[22:0] != 23'd0);
    a_inf_s      = (a_i[30:23] == 8'hFF) && (a_i[22:0] == 23'd0);
    b_inf_s      = (b_i[30:23] == 8'hFF) && (b_i[22:0] == 23'd0);
    a_ge_s       = (a_i[30:0] >= b_i[30:0]);
    big_s        = a_ge_s ? a_i : b_i;
    small_s      = a_ge_s ? b_i : a_i;
    big_sign_s   = big_s[31];
    small_sign_s = small_s[31];
    big_exp_s    = (big_s[30:23] == 8'd0) ? 8'd1 : big_s[30:23];
    small_exp_s  = (small_s[30:23] == 8'd0) ? 8'd1 : small_s[30:23];
    big_man_s    = {(big_s[30:23] != 8'd0), big_s[22:0]};
    small_man_s  = {(small_s[30:23] != 8'd0), small_s[22:0]};
    diff_s       = big_exp_s - small_exp_s;
    small_ext_s  = {small_man_s, 3'b000};

    // Bits shifted out of the smaller operand collapse into the sticky LSB
    if (diff_s >= 8'd27) begin
      aligned_s = {26'd0, (small_man_s != 24'd0)};
    end else begin
      aligned_s    = small_ext_s >> diff_s;
      aligned_s[0] = aligned_s[0] | ((small_ext_s & ((27'd1 << diff_s) - 27'd1)) != 27'd0);
    end

    if (big_sign_s == small_sign_s) begin
      sum_s = {1'b0, big_man_s, 3'b000} + {1'b0, aligned_s};
    end else begin
      sum_s = {1'b0, big_man_s, 3'b000} - {1'b0, aligned_s};
    end

    lz_s = 5'd27;
    for (int i = 0; i < 27; i++) begin
      if (sum_s[i]) begin
        lz_s = 5'(26 - i);
      end else begin
        lz_s = lz_s;
      end
    end

    exp_s       = {2'b00, big_exp_s};
    shift_lim_s = exp_s - 10'd1;
    shift_s     = 5'd0;
    if (sum_s[27]) begin
      norm_s    = sum_s[27:1];
      norm_s[0] = sum_s[1] | sum_s[0];
      exp_s     = exp_s + 10'd1;
    end else begin
      shift_s = ({5'd0, lz_s} < shift_lim_s) ? lz_s : shift_lim_s[4:0];
      norm_s  = sum_s[26:0] << shift_s;
      exp_s   = exp_s - {5'd0, shift_s};
    end

    round_up_s = norm_s[2] & (norm_s[1] | norm_s[0] | norm_s[3]);
    man_r_s    = {1'b0, norm_s[26:3]} + {24'd0, round_up_s};
    if (man_r_s[24]) begin
      man_r_s = man_r_s >> 1;
      exp_s   = exp_s + 10'd1;
    end else begin
      man_r_s = man_r_s;
    end

    if (exp_s >= 10'd255) begin
      sum_o = {big_sign_s, 8'hFF, 23'd0};
    end else begin
      sum_o = {big_sign_s, (man_r_s[23] ? exp_s[7:0] : 8'd0), man_r_s[22:0]};
    end

    if (a_nan_s || b_nan_s || (a_inf_s && b_inf_s && (a_i[31] != b_i[31]))) begin
      sum_o = 32'h7FC0_0000;
    end else if (a_inf_s) begin
      sum_o = a_i;
    end else if (b_inf_s) begin
      sum_o = b_i;
    end else if (sum_s == 28'd0) begin
      sum_o = {(big_sign_s & small_sign_s), 31'd0};
    end else begin
      sum_o = sum_o;
    end
  end
endmodule

module vector_add_sequencer #(
  parameter int VLEN = 4
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 start,
  input  logic [32*VLEN-1:0]   A,
  input  logic [32*VLEN-1:0]   B,
  output logic                 ready,
  output logic                 busy,
  output logic [32*VLEN-1:0]   result,
  output logic                 result_valid,
  input  logic                 result_ready
);
  localparam int IDX_W = (VLEN > 1) ? $clog2(VLEN) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(VLEN - 1);

  typedef enum logic [1:0] {IDLE = 2'd0, RUN = 2'd1, HOLD = 2'd2} state_e;

  state_e           state_q, state_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic [31:0]      a_q [VLEN];
  logic [31:0]      a_d [VLEN];
  logic [31:0]      b_q [VLEN];
  logic [31:0]      b_d [VLEN];
  logic [31:0]      res_q [VLEN];
  logic [31:0]      res_d [VLEN];
  logic             ready_q, ready_d, busy_q, busy_d, valid_q, valid_d;
  logic [31:0]      sum_s;

  FloatingAddition u_fadd (
    .a_i  (a_q[idx_q]),
    .b_i  (b_q[idx_q]),
    .sum_o(sum_s)
  );

  // Next-state: operands are captured only on an accepted start, so later A/B changes are invisible
  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    a_d     = a_q;
    b_d     = b_q;
    res_d   = res_q;
    case (state_q)
      IDLE: begin
        if (start) begin
          for (int i = 0; i < VLEN; i++) begin
            a_d[i] = A[32*i +: 32];
            b_d[i] = B[32*i +: 32];
          end
          idx_d   = '0;
          state_d = RUN;
        end else begin
          state_d = IDLE;
        end
      end
      RUN: begin
        res_d[idx_q] = sum_s;
        if (idx_q == LAST_IDX) begin
          state_d = HOLD;
        end else begin
          idx_d = idx_q + IDX_W'(1);
        end
      end
      HOLD: begin
        if (result_ready) begin
          state_d = IDLE;
        end else begin
          state_d = HOLD;
        end
      end
      default: begin
        state_d = IDLE;
        idx_d   = '0;
      end
    endcase
    ready_d = (state_d == IDLE);
    busy_d  = (state_d == RUN);
    valid_d = (state_d == HOLD);
  end

  // State, operand, result and status registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      idx_q   <= '0;
      ready_q <= 1'b1;
      busy_q  <= 1'b0;
      valid_q <= 1'b0;
      for (int i = 0; i < VLEN; i++) begin
        a_q[i]   <= 32'd0;
        b_q[i]   <= 32'd0;
        res_q[i] <= 32'd0;
      end
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      ready_q <= ready_d;
      busy_q  <= busy_d;
      valid_q <= valid_d;
      for (int i = 0; i < VLEN; i++) begin
        a_q[i]   <= a_d[i];
        b_q[i]   <= b_d[i];
        res_q[i] <= res_d[i];
      end
    end
  end

  for (genvar g = 0; g < VLEN; g++) begin : g_result
    assign result[32*g +: 32] = res_q[g];
  end

  assign ready        = ready_q;
  assign busy         = busy_q;
  assign result_valid = valid_q;
endmodule

// File: tb/tb_vector_add_sequencer.sv
// Directed bench for vector_add_sequencer: a VLEN=4 instance for sequencing, hold,
// reset and start-masking, and a VLEN=1 instance for the single-element latency case.

module tb_vector_add_sequencer;
  localparam int VLEN = 4;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_n;
  logic start4, ready4, busy4, valid4, rr4;
  logic [32*VLEN-1:0] a4, b4, res4;
  logic start1, ready1, busy1, valid1, rr1;
  logic [31:0] a1, b1, res1;

  int checks = 0;
  int failures = 0;

  // Element 0 is the rightmost word
  localparam logic [127:0] V1_A = {32'h40000000, 32'h3F000000, 32'h3FC00000, 32'h3F800000};
  localparam logic [127:0] V1_B = {32'h40000000, 32'h3E800000, 32'h3FC00000, 32'h40000000};
  localparam logic [127:0] V1_R = {32'h40800000, 32'h3F400000, 32'h40400000, 32'h40400000};
  localparam logic [127:0] V2_A = {32'h00000000, 32'hBF800000, 32'h40400000, 32'h3F800000};
  localparam logic [127:0] V2_B = {32'h3F800000, 32'h3F800000, 32'h3F800000, 32'hBF000000};
  localparam logic [127:0] V2_R = {32'h3F800000, 32'h00000000, 32'h40800000, 32'h3F000000};
  localparam logic [127:0] V3_A = {32'h40000000, 32'h3F800000, 32'h4B800000, 32'h4B800000};
  localparam logic [127:0] V3_B = {32'h40000000, 32'h3F800000, 32'h40400000, 32'h3F800000};
  localparam logic [127:0] V3_R = {32'h40800000, 32'h40000000, 32'h4B800002, 32'h4B800000};

  vector_add_sequencer #(.VLEN(VLEN)) u_dut4 (
    .clk(clk), .rst_n(rst_n), .start(start4), .A(a4), .B(b4),
    .ready(ready4), .busy(busy4), .result(res4),
    .result_valid(valid4), .result_ready(rr4)
  );

  vector_add_sequencer #(.VLEN(1)) u_dut1 (
    .clk(clk), .rst_n(rst_n), .start(start1), .A(a1), .B(b1),
    .ready(ready1), .busy(busy1), .result(res1),
    .result_valid(valid1), .result_ready(rr1)
  );

  task automatic check_eq(input string tag, input logic [127:0] got, input logic [127:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic launch4(input logic [127:0] a, input logic [127:0] b);
    a4 = a; b4 = b; start4 = 1'b1;
    tick();
    start4 = 1'b0;
  endtask

  initial begin
    rst_n = 1'b0;
    start4 = 1'b0; rr4 = 1'b0; a4 = '0; b4 = '0;
    start1 = 1'b0; rr1 = 1'b0; a1 = '0; b1 = '0;
    #12;
    check_eq("rst_ready", ready4, 1'b1);
    check_eq("rst_busy", busy4, 1'b0);
    check_eq("rst_valid", valid4, 1'b0);
    check_eq("rst_result", res4, '0);
    check_eq("rst_ready1", ready1, 1'b1);
    @(posedge clk); #1; rst_n = 1'b1;

    // Basic vector add: busy for exactly VLEN cycles then valid
    launch4(V1_A, V1_B);
    check_eq("run_busy0", busy4, 1'b1);
    check_eq("run_ready0", ready4, 1'b0);
    for (int i = 1; i < VLEN; i++) begin
      tick();
      check_eq("run_busy", busy4, 1'b1);
      check_eq("run_valid", valid4, 1'b0);
    end
    tick();
    check_eq("v1_valid", valid4, 1'b1);
    check_eq("v1_busy", busy4, 1'b0);
    check_eq("v1_result", res4, V1_R);

    // Hold with no acknowledge
    for (int i = 0; i < 10; i++) begin
      tick();
      check_eq("hold_valid", valid4, 1'b1);
      check_eq("hold_result", res4, V1_R);
    end
    rr4 = 1'b1;
    tick();
    rr4 = 1'b0;
    check_eq("ack_ready", ready4, 1'b1);
    check_eq("ack_valid", valid4, 1'b0);
    check_eq("idle_keeps_result", res4, V1_R);

    // Operand churn and start held high during RUN
    a4 = V2_A; b4 = V2_B; start4 = 1'b1;
    tick();
    for (int i = 1; i < VLEN; i++) begin
      a4 = {$urandom, $urandom, $urandom, $urandom};
      b4 = {$urandom, $urandom, $urandom, $urandom};
      tick();
      check_eq("churn_busy", busy4, 1'b1);
    end
    tick();
    check_eq("v2_valid", valid4, 1'b1);
    check_eq("v2_result", res4, V2_R);
    tick();
    check_eq("hold_ignores_start", valid4, 1'b1);
    start4 = 1'b0;
    rr4 = 1'b1;
    tick();
    rr4 = 1'b0;
    check_eq("v2_release", ready4, 1'b1);

    // start together with result_ready in HOLD returns to IDLE only
    launch4(V1_A, V1_B);
    repeat (VLEN) tick();
    check_eq("v1b_valid", valid4, 1'b1);
    a4 = V3_A; b4 = V3_B;
    start4 = 1'b1; rr4 = 1'b1;
    tick();
    rr4 = 1'b0;
    check_eq("both_ready", ready4, 1'b1);
    check_eq("both_busy", busy4, 1'b0);
    tick();
    start4 = 1'b0;
    check_eq("next_start_busy", busy4, 1'b1);
    repeat (VLEN) tick();
    check_eq("v3_valid", valid4, 1'b1);
    check_eq("v3_result", res4, V3_R);
    rr4 = 1'b1;
    tick();
    rr4 = 1'b0;

    // Asynchronous reset after two RUN cycles
    launch4(V2_A, V2_B);
    tick();
    tick();
    #2;
    rst_n = 1'b0;
    #1;
    check_eq("midrun_ready", ready4, 1'b1);
    check_eq("midrun_busy", busy4, 1'b0);
    check_eq("midrun_valid", valid4, 1'b0);
    check_eq("midrun_result", res4, '0);
    @(posedge clk); #1; rst_n = 1'b1;
    launch4(V3_A, V3_B);
    check_eq("post_rst_busy", busy4, 1'b1);
    repeat (VLEN) tick();
    check_eq("post_rst_valid", valid4, 1'b1);
    check_eq("post_rst_result", res4, V3_R);

    // Single-element instance
    a1 = 32'h3F800000; b1 = 32'h3F800000; start1 = 1'b1;
    tick();
    start1 = 1'b0;
    check_eq("v1len_busy", busy1, 1'b1);
    check_eq("v1len_valid0", valid1, 1'b0);
    tick();
    check_eq("v1len_valid", valid1, 1'b1);
    check_eq("v1len_result", res1, 32'h40000000);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/vector_add_sequencer.md
VECTOR_ADD_SEQUENCER -- requirements
Module: vector_add_sequencer

Interface
REQ-001 The block SHALL have parameter VLEN, default 4, giving the number of 32-bit IEEE-754 single-precision elements per vector (legal range VLEN >= 1).
REQ-002 The block SHALL have one clock and an asynchronous, active-low reset.
REQ-003 Port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-004 Port rst_n, input, 1 bit: asynchronous, active-low reset.
REQ-005 Port start, input, 1 bit: request to begin a vector add; sampled only when ready=1.
REQ-006 Port A, input, 32*VLEN bits: operand vector; element i is A[32*i +: 32].
REQ-007 Port B, input, 32*VLEN bits: operand vector; element i is B[32*i +: 32].
REQ-008 Port ready, output, 1 bit: high when the block is IDLE and able to accept start.
REQ-009 Port busy, output, 1 bit: high while in RUN.
REQ-010 Port result, output, 32*VLEN bits: registered element-wise sum; element i is result[32*i +: 32].
REQ-011 Port result_valid, output, 1 bit: high while result holds a complete, unconsumed vector.
REQ-012 Port result_ready, input, 1 bit: consumer acknowledge for result.

Function
REQ-013 The block SHALL contain exactly one FloatingAddition instance, time-shared across all elements, with no other arithmetic on float data.
REQ-014 The block SHALL implement a three-state FSM: IDLE, RUN, HOLD.
REQ-015 IDLE: ready=1, busy=0, result_valid=0; on a rising edge with start=1, latch A and B into internal operand registers, clear index idx to 0, and go to RUN.
REQ-016 RUN: each cycle, write FloatingAddition(A_reg[idx], B_reg[idx]) into result element idx; if idx==VLEN-1, go to HOLD; otherwise idx increments by 1.
REQ-017 idx SHALL be max(1, ceil(log2(VLEN))) bits wide and SHALL never exceed VLEN-1.
REQ-018 HOLD: result_valid=1 and result stable; on a rising edge with result_ready=1, go to IDLE; otherwise stay in HOLD indefinitely.
REQ-019 Latency: with start accepted at edge 0, result_valid SHALL first be high after edge VLEN (VLEN cycles in RUN); VLEN=1 gives exactly one RUN cycle.
REQ-020 start SHALL be ignored in RUN and HOLD, including in the HOLD cycle in which result_ready=1; a new start is accepted only from IDLE on a later edge.
REQ-021 Changes on A or B after acceptance SHALL NOT affect the result in progress.
REQ-022 result SHALL retain its last value in IDLE and update only in RUN; elements not yet written in RUN retain their previous values.
REQ-023 result_ready SHALL have no effect outside HOLD.
REQ-024 All outputs SHALL be driven from registers or decoded directly from FSM state, with no combinational path from inputs to outputs.

Reset
REQ-025 On rst_n=0, asynchronously and regardless of state (including mid-RUN), the block SHALL enter IDLE with idx=0, result=0, operand registers=0, ready=1, busy=0, and result_valid=0.
REQ-026 After rst_n deasserts, the first start SHALL be accepted on the first rising edge on which start=1.

Verification
REQ-027 VLEN=4, A={3F800000, 3FC00000, 3F000000, 40000000} (element 0 first), B={40000000, 3FC00000, 3E800000, 40000000}, start pulsed -> busy for 4 cycles, then result_valid=1 with result={40400000, 40400000, 3F400000, 40800000}.
REQ-028 Hold result_ready=0 for 10 cycles in HOLD -> result_valid stays 1 and result stays constant; then result_ready=1 -> IDLE on the next edge with ready=1.
REQ-029 Toggle A and B and pulse start during RUN -> result equals the sums of the originally latched operands, and no second operation starts.
REQ-030 Assert rst_n=0 after 2 RUN cycles -> outputs go immediately to reset values; a following start with fresh operands completes correctly.
REQ-031 VLEN=1, A=3F800000, B=3F800000 -> result_valid after exactly 1 RUN cycle with result=40000000.
REQ-032 Assert start and result_ready together during HOLD -> return to IDLE only, with start ignored; start on the next edge is accepted.
